// File: rtl/best_1ofn_pipe_pkg.sv
// Shared field-width defaults, width-derivation helpers and the tree node
// layout for the best-1-of-N selector.
package pattern_params;

   localparam int NCH_DEF       = 7;
   localparam int PATB_DEF      = 7;
   localparam int KEYB_DEF      = 5;
   localparam int OFFSB_DEF     = 4;
   localparam int QLTB_DEF      = 6;
   localparam int BNDB_DEF      = 5;
   localparam int CARB_DEF      = 11;
   localparam int CNTB_DEF      = 16;
   localparam int SEG_SPLIT_DEF = 128;

   // Sort key is wide enough for either qlt or pat without its bend bit.
   function automatic int skb_f(input int qltb, input int patb);
      return (qltb > patb - 1) ? qltb : patb - 1;
   endfunction

   // Channel index width; never below one bit.
   function automatic int idxb_f(input int nch);
      return (nch <= 2) ? 1 : $clog2(nch);
   endfunction

   localparam int SKB_DEF  = skb_f(QLTB_DEF, PATB_DEF);
   localparam int IDXB_DEF = idxb_f(NCH_DEF);

   // Sort key sits in the MSBs so a node can compare the top slice directly.
   typedef struct packed {
      logic [SKB_DEF-1:0]   skey;
      logic [PATB_DEF-1:0]  pat;
      logic [KEYB_DEF-1:0]  key;
      logic [OFFSB_DEF-1:0] offs;
      logic [QLTB_DEF-1:0]  qlt;
      logic [BNDB_DEF-1:0]  bend;
      logic [CARB_DEF-1:0]  carry;
      logic [IDXB_DEF-1:0]  idx;
   } node_t;

endpackage

// File: rtl/best_1ofn_pipe_node.sv
// Registered pairwise compare: one node of the selection tree.
// Operand a always comes from the lower channel indices, b from the higher.
module best_1of2_node
   import pattern_params::*;
#(
   parameter int W   = $bits(node_t),
   parameter int SKB = SKB_DEF
)(
   input  logic         clock,
   input  logic         reset_n,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // Take b only when strictly better so ties resolve to the lower channel.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         y <= '0;
      else if (b[W-1 -: SKB] > a[W-1 -: SKB])
         y <= b;
      else
         y <= a;
   end

endmodule

// File: rtl/best_1ofn_pipe.sv
// Pipelined best-1-of-N CLCT selector with clamped subkey and per-channel
// saturating win counters. Latency clog2(NCH)+2.
// Optional feature: define BEST_SUBKEY_CLAMP_EN to clamp the subkey into the
// winner's key segment; otherwise the subkey wraps modulo its width.
module best_1ofn_pipe
   import pattern_params::*;
#(
   parameter int NCH         = NCH_DEF,
   parameter int PATB        = PATB_DEF,
   parameter int KEYB        = KEYB_DEF,
   parameter int OFFSB       = OFFSB_DEF,
   parameter int QLTB        = QLTB_DEF,
   parameter int BNDB        = BNDB_DEF,
   parameter int CARB        = CARB_DEF,
   parameter int SORT_ON_QLT = 0,
   parameter int SEG_SPLIT   = SEG_SPLIT_DEF,
   parameter int CNTB        = CNTB_DEF,
   localparam int SKB        = skb_f(QLTB, PATB),
   localparam int IDXB       = idxb_f(NCH),
   localparam int GKB        = IDXB + KEYB
)(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  din_vld,
   input  logic [NCH*PATB-1:0]   pat,
   input  logic [NCH*KEYB-1:0]   key,
   input  logic [NCH*OFFSB-1:0]  offs,
   input  logic [NCH*QLTB-1:0]   qlt,
   input  logic [NCH*BNDB-1:0]   bend,
   input  logic [NCH*CARB-1:0]   carry,
   input  logic                  cnt_clear,
   output logic                  best_vld,
   output logic                  best_found,
   output logic [PATB-1:0]       best_pat,
   output logic [QLTB-1:0]       best_qlt,
   output logic [BNDB-1:0]       best_bend,
   output logic [CARB-1:0]       best_carry,
   output logic [GKB-1:0]        best_key,
   output logic [GKB+1:0]        best_subkey,
   output logic [NCH*CNTB-1:0]   win_cnt
);

   // Same layout as pattern_params::node_t, sized for this instance.
   typedef struct packed {
      logic [SKB-1:0]   skey;
      logic [PATB-1:0]  pat;
      logic [KEYB-1:0]  key;
      logic [OFFSB-1:0] offs;
      logic [QLTB-1:0]  qlt;
      logic [BNDB-1:0]  bend;
      logic [CARB-1:0]  carry;
      logic [IDXB-1:0]  idx;
   } node_s;

   localparam int NW = $bits(node_s);
   localparam int NP = 1 << IDXB;   // leaves after padding to a power of two

   genvar gi;

   if (NCH < 2 || NCH > 16 || SEG_SPLIT < 1 || SEG_SPLIT > (NCH << KEYB)) begin : g_bad_params
      $error("best_1ofn_pipe: unsupported NCH/SEG_SPLIT combination");
   end

   node_s           cand [NCH];
   node_s           s0_reg [NCH];
   logic [NW-1:0]   heap [2*NP-1];    // heap[0] is the root, leaves start at NP-1
   logic [IDXB:0]   vld_reg;
   node_s           root;
   logic [GKB-1:0]  gkey;
   logic [GKB+1:0]  sub_next;
   logic            inc_reg;
   logic [IDXB-1:0] inc_idx_reg;
   logic [CNTB-1:0] cnt_reg [NCH];

   // Unpack each channel into a node, sort key chosen at elaboration.
   for (gi = 0; gi < NCH; gi++) begin : g_cand
      logic [SKB-1:0] skey;
      if (SORT_ON_QLT != 0) begin : g_qlt
         assign skey = SKB'(qlt[gi*QLTB +: QLTB]);
      end else begin : g_pat
         assign skey = SKB'(pat[gi*PATB+1 +: PATB-1]);
      end
      assign cand[gi] = {skey, pat[gi*PATB +: PATB], key[gi*KEYB +: KEYB],
                         offs[gi*OFFSB +: OFFSB], qlt[gi*QLTB +: QLTB],
                         bend[gi*BNDB +: BNDB], carry[gi*CARB +: CARB], IDXB'(gi)};
   end

   // Stage 0: capture all candidates.
   always_ff @(posedge clock or negedge reset_n) begin
      for (int i = 0; i < NCH; i++) begin
         if (!reset_n) s0_reg[i] <= '0;
         else          s0_reg[i] <= cand[i];
      end
   end

   // Leaves: real channels, then zero-key padding that can never win.
   for (gi = 0; gi < NP; gi++) begin : g_leaf
      if (gi < NCH) begin : g_ch
         assign heap[NP-1+gi] = s0_reg[gi];
      end else begin : g_pad
         assign heap[NP-1+gi] = '0;
      end
   end

   // One registered node per internal heap slot; left child is lower index.
   for (gi = 0; gi < NP-1; gi++) begin : g_node
      best_1of2_node #(.W(NW), .SKB(SKB)) u_node (
         .clock   (clock),
         .reset_n (reset_n),
         .a       (heap[2*gi+1]),
         .b       (heap[2*gi+2]),
         .y       (heap[gi])
      );
   end

   assign root = heap[0];
   assign gkey = {root.idx, root.key};

   // Valid bit travels alongside stage 0 and each tree level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) vld_reg <= '0;
      else          vld_reg <= {vld_reg[IDXB-1:0], din_vld};
   end

`ifdef BEST_SUBKEY_CLAMP_EN
   int sk_i, lo_i, hi_i;

   // Subkey in 1/8-strip units, clamped to the winner's key segment.
   always_comb begin
      sk_i = 4 * int'(gkey) + int'($signed(root.offs));
      if (int'(gkey) < SEG_SPLIT) begin
         lo_i = 0;
         hi_i = 4 * SEG_SPLIT - 1;
      end else begin
         lo_i = 4 * SEG_SPLIT;
         hi_i = 4 * NCH * (1 << KEYB) - 1;
      end
      if (sk_i < lo_i)      sk_i = lo_i;
      else if (sk_i > hi_i) sk_i = hi_i;
      sub_next = sk_i[GKB+1:0];
   end
`else
   // Unclamped subkey simply wraps at the output width.
   assign sub_next = {gkey, 2'b00} + (GKB+2)'($signed(root.offs));
`endif

   // Output stage: fields only move on a valid set, otherwise they hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         best_vld    <= 1'b0;
         best_found  <= 1'b0;
         best_pat    <= '0;
         best_qlt    <= '0;
         best_bend   <= '0;
         best_carry  <= '0;
         best_key    <= '0;
         best_subkey <= '0;
      end else begin
         best_vld <= vld_reg[IDXB];
         if (vld_reg[IDXB]) begin
            best_found  <= (root.skey != '0);
            best_pat    <= root.pat;
            best_qlt    <= root.qlt;
            best_bend   <= root.bend;
            best_carry  <= root.carry;
            best_key    <= gkey;
            best_subkey <= sub_next;
         end
      end
   end

   // Latch the win request so the counter update lands one cycle later.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inc_reg     <= 1'b0;
         inc_idx_reg <= '0;
      end else begin
         inc_reg     <= best_vld & best_found;
         inc_idx_reg <= best_key[GKB-1 -: IDXB];
      end
   end

   // Saturating win counters; clear has priority over an increment.
   always_ff @(posedge clock or negedge reset_n) begin
      for (int i = 0; i < NCH; i++) begin
         if (!reset_n)
            cnt_reg[i] <= '0;
         else if (cnt_clear)
            cnt_reg[i] <= '0;
         else if (inc_reg && inc_idx_reg == IDXB'(i) && cnt_reg[i] != '1)
            cnt_reg[i] <= cnt_reg[i] + CNTB'(1);
      end
   end

   for (gi = 0; gi < NCH; gi++) begin : g_cnt_out
      assign win_cnt[gi*CNTB +: CNTB] = cnt_reg[gi];
   end

endmodule
